// File: rtl/div_iter_core.sv
// Iterative radix-2 restoring unsigned divider; C = {remainder, quotient}, one bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: B==0 or A<B finishes on the start edge without iterating.
//
// state | meaning
// IDLE  | input_init=1; a valid at the edge latches A/B and starts a divide
// BUSY  | one quotient bit per cycle; valid low aborts back to IDLE
// DONE  | done=1 for one cycle with C loaded, then IDLE regardless of valid
module div_iter_core #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 input_init,
    output logic                 done,
    output logic [2*WIDTH-1:0]   C
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     div_q;
    logic [2*WIDTH-1:0]   c_q;
    logic                 done_q;
    logic                 init_q;

    logic [WIDTH:0]       rem_shift_d;
    logic                 ge_d;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     q_d;

    // The partial remainder stays below the divisor, so the W-bit wrap of the
    // subtraction is exact whenever the W+1-bit compare says it is taken.
    always_comb begin
        rem_shift_d = {rem_q, q_q[WIDTH-1]};
        ge_d        = (rem_shift_d >= {1'b0, div_q});
        rem_d       = ge_d ? (rem_shift_d[WIDTH-1:0] - div_q) : rem_shift_d[WIDTH-1:0];
        q_d         = {q_q[WIDTH-2:0], ge_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            init_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (valid) begin
                        q_q    <= A;
                        div_q  <= B;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        init_q <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
                        if (B == '0) begin
                            c_q     <= {A, {WIDTH{1'b1}}};
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (A < B) begin
                            c_q     <= {A, {WIDTH{1'b0}}};
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
`else
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (!valid) begin
                        state_q <= IDLE;
                        init_q  <= 1'b1;
                    end else begin
                        q_q   <= q_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            c_q     <= {rem_d, q_d};
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    init_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    init_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign input_init = init_q;
    assign done       = done_q;
    assign C          = c_q;

endmodule

// File: tb/tb_div_iter_core.sv
// Directed bench for div_iter_core: hand-computed quotients/remainders, latency,
// abort, asynchronous reset mid-divide and back-to-back starts.
module tb_div_iter_core;

    logic          clk;
    logic          reset;
    logic          valid;
    logic [63:0]   A;
    logic [63:0]   B;
    logic          input_init;
    logic          done;
    logic [127:0]  C;

    int tests = 0;
    int fails = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SHORT = 1;
`else
    localparam int LAT_SHORT = 65;
`endif

    div_iter_core #(.WIDTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .A          (A),
        .B          (B),
        .input_init (input_init),
        .done       (done),
        .C          (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges (continuing from 'already') until done is seen; -1 on timeout.
    task automatic wait_done(input int already, output int n);
        n = -1;
        for (int i = already + 1; i <= already + 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    // Called at a negedge while idle; leaves valid low at the negedge after done.
    task automatic do_div(input logic [63:0] a, input logic [63:0] b, input int lat,
                          input logic [127:0] exp_c, input string tag);
        int n;
        A = a;
        B = b;
        valid = 1'b1;
        wait_done(0, n);
        chk({tag, "_latency"}, 128'(n), 128'(lat));
        chk({tag, "_c"}, C, exp_c);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {127'd0, done}, 128'd0);
        chk({tag, "_idle_after"}, {127'd0, input_init}, 128'd1);
        valid = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        reset = 1'b0;
        valid = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        chk("rst_init", {127'd0, input_init}, 128'd1);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_c", C, 128'd0);
        reset = 1'b1;
        @(negedge clk);

        // 100 / 7 = 14 r 2, operands scrambled while busy
        A = 64'd100;
        B = 64'd7;
        valid = 1'b1;
        @(negedge clk);
        chk("c1_busy_init", {127'd0, input_init}, 128'd0);
        chk("c1_busy_done", {127'd0, done}, 128'd0);
        A = '1;
        B = 64'd1;
        wait_done(1, n);
        chk("c1_latency", 128'(n), 128'd65);
        chk("c1_c", C, {64'd2, 64'd14});
        @(negedge clk);
        chk("c1_done_one_cycle", {127'd0, done}, 128'd0);
        chk("c1_idle_after", {127'd0, input_init}, 128'd1);
        valid = 1'b0;
        @(negedge clk);

        // divide by zero: quotient all ones, remainder = A
        do_div(64'd5, 64'd0, LAT_SHORT, {64'd5, 64'hFFFF_FFFF_FFFF_FFFF}, "div0");
        @(negedge clk);

        // A < B: quotient 0, remainder A
        do_div(64'd3, 64'd10, LAT_SHORT, {64'd3, 64'd0}, "a_lt_b");
        @(negedge clk);
`ifdef DIV_EARLY_OUT_EN
        do_div(64'd7, 64'd0, 1, {64'd7, 64'hFFFF_FFFF_FFFF_FFFF}, "eo_div0");
        @(negedge clk);
`endif

        // abort at busy cycle 10; C must keep the previous result
        A = 64'd1000;
        B = 64'd3;
        valid = 1'b1;
        repeat (10) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("abort_idle", {127'd0, input_init}, 128'd1);
        chk("abort_done", {127'd0, done}, 128'd0);
`ifdef DIV_EARLY_OUT_EN
        chk("abort_c_held", C, {64'd7, 64'hFFFF_FFFF_FFFF_FFFF});
`else
        chk("abort_c_held", C, {64'd3, 64'd0});
`endif
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", {127'd0, seen}, 128'd0);
        do_div(64'd9, 64'd3, 65, {64'd0, 64'd3}, "after_abort");
        @(negedge clk);

        // asynchronous reset between edges at busy cycle 20
        A = 64'd1000;
        B = 64'd3;
        valid = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_done", {127'd0, done}, 128'd0);
        chk("async_rst_c", C, 128'd0);
        chk("async_rst_init", {127'd0, input_init}, 128'd1);
        valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_div(64'd20, 64'd4, 65, {64'd0, 64'd5}, "post_rst");
        @(negedge clk);

        // back-to-back with valid held; second operands resampled after DONE
        A = 64'h8000_0000_0000_0000;
        B = 64'd2;
        valid = 1'b1;
        wait_done(0, n);
        chk("b2b1_latency", 128'(n), 128'd65);
        chk("b2b1_c", C, {64'd0, 64'h4000_0000_0000_0000});
        A = 64'hFFFF_FFFF_FFFF_FFFF;
        B = 64'd16;
        wait_done(0, n);
        chk("b2b_gap", 128'(n), 128'd66);
        chk("b2b2_c", C, {64'd15, 64'h0FFF_FFFF_FFFF_FFFF});
        valid = 1'b0;
        @(negedge clk);
        chk("b2b_done_one_cycle", {127'd0, done}, 128'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
